// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and PC-select codes.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_INT_SEQ  = 2'd2
  } state_t;

  localparam logic [1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] PC_SEL_BR  = 2'd1;
  localparam logic [1:0] PC_SEL_INT = 2'd2;

endpackage

// File: rtl/pipe_load_use_detect.sv
// Load-use hazard detector: flags when the ID instruction reads the register an EX load writes.
module pipe_load_use_detect #(
  parameter int REG_ADDR_W = 3
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  load_use
);

  assign load_use = ex_mem_read &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: FSM, interrupt-entry counter and per-buffer enable/flush decode.
// Optional statistics counters are built when PIPE_CTRL_STATS_EN is defined.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int INT_CYCLES = 2,
  parameter int STAT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  input  logic                  int_req,
  output logic                  pc_write_en,
  output logic [1:0]            pc_sel,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic                  int_push,
  output logic                  int_ack,
  output logic [STAT_W-1:0]     stall_cnt,
  output logic [STAT_W-1:0]     flush_cnt
);

  localparam int CNT_W = (INT_CYCLES > 1) ? $clog2(INT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] INT_LOAD = CNT_W'(INT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] int_cnt, int_cnt_nxt;
  logic             load_use;

  pipe_load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  always_comb begin
    pc_write_en = 1'b1;
    pc_sel      = PC_SEL_SEQ;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b1;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b1;
    int_push    = 1'b0;
    int_ack     = 1'b0;
    state_nxt   = state;
    int_cnt_nxt = int_cnt;
    if (!rst_n) begin
      pc_write_en = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_nxt   = ST_RUN;
      int_cnt_nxt = '0;
    end else begin
      case (state)
        ST_RUN: begin
          // One event per cycle; lower-priority events stay pending on their inputs.
          if (mem_busy) begin
            pc_write_en = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_mem_en   = 1'b0;
            state_nxt   = ST_MEM_WAIT;
          end else if (ex_branch_taken) begin
            pc_sel      = PC_SEL_BR;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (int_req) begin
            pc_write_en = 1'b0;
            if_id_flush = 1'b1;
            int_cnt_nxt = INT_LOAD;
            state_nxt   = ST_INT_SEQ;
          end else if (load_use) begin
            pc_write_en = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          // Stay frozen through the cycle busy drops so memory data settles first.
          pc_write_en = 1'b0;
          if_id_en    = 1'b0;
          id_ex_en    = 1'b0;
          ex_mem_en   = 1'b0;
          if (!mem_busy) state_nxt = ST_RUN;
        end
        ST_INT_SEQ: begin
          if (mem_busy) begin
            pc_write_en = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_mem_en   = 1'b0;
          end else begin
            int_push    = 1'b1;
            if_id_flush = 1'b1;
            pc_write_en = 1'b0;
            if (int_cnt == '0) begin
              pc_sel      = PC_SEL_INT;
              pc_write_en = 1'b1;
              int_ack     = 1'b1;
              state_nxt   = ST_RUN;
            end else begin
              int_cnt_nxt = int_cnt - 1'b1;
            end
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      int_cnt <= '0;
    end else begin
      state   <= state_nxt;
      int_cnt <= int_cnt_nxt;
    end
  end

`ifdef PIPE_CTRL_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [STAT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write_en) stall_q <= sat_inc(stall_q);
      if (if_id_flush || id_ex_flush) flush_q <= sat_inc(flush_q);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
